// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus between the sequencer/memory side (master) and fetch_unit (slave).
interface fetch_unit_if;
  logic        inst_wr;
  logic        decoder_en;
  logic [1:0]  pc_op;
  logic        flag;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [3:0]  opcode;
  logic [3:0]  rD_sel;
  logic [3:0]  rA_sel;
  logic [3:0]  rB_sel;
  logic [7:0]  imm;
  logic        stack_err;

  modport master (
    output inst_wr, decoder_en, pc_op, flag, imem_data,
    input  imem_addr, opcode, rD_sel, rA_sel, rB_sel, imm, stack_err
  );

  modport slave (
    input  inst_wr, decoder_en, pc_op, flag, imem_data,
    output imem_addr, opcode, rD_sel, rA_sel, rB_sel, imm, stack_err
  );
endinterface

// File: rtl/fetch_unit.sv
// PC, instruction register and latched decode fields for a 16-bit core.
// Define RETURN_STACK_EN to add a 4-entry CALL/RET return-address stack.
module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  fetch_unit_if.slave bus
);
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;

  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [7:0]  imm_q, imm_d;
  logic [15:0] pc_inc;
  logic [15:0] pc_br;

  assign pc_inc = pc_q + 16'd1;
  assign pc_br  = pc_q + {{8{imm_q[7]}}, imm_q};

`ifdef RETURN_STACK_EN
  // Circular buffer: sp_q is the next write slot, cnt_q the live entries (0..4).
  logic [15:0] stk_q [4];
  logic [15:0] stk_d [4];
  logic [1:0]  sp_q, sp_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    imm_d    = imm_q;
`ifdef RETURN_STACK_EN
    stk_d = stk_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    err_d = err_q;
`endif

    if (bus.inst_wr) ir_d = bus.imem_data;

    // Fields come from the pre-edge IR, giving the fetch-then-decode pipeline.
    if (bus.decoder_en) begin
      opcode_d = ir_q[15:12];
      rd_d     = ir_q[11:8];
      ra_d     = ir_q[7:4];
      rb_d     = ir_q[3:0];
      imm_d    = ir_q[7:0];
    end

    case (bus.pc_op)
      2'b00: pc_d = pc_q;
      2'b01: pc_d = pc_inc;
      2'b10: begin
`ifdef RETURN_STACK_EN
        if (opcode_q == OP_CALL) begin
          stk_d[sp_q] = pc_inc;
          sp_d        = sp_q + 2'd1;
          pc_d        = pc_br;
          if (cnt_q == 3'd4) err_d = 1'b1;
          else               cnt_d = cnt_q + 3'd1;
        end else if (opcode_q == OP_RET) begin
          if (cnt_q == 3'd0) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d  = stk_q[sp_q - 2'd1];
            sp_d  = sp_q - 2'd1;
            cnt_d = cnt_q - 3'd1;
          end
        end else begin
          pc_d = bus.flag ? pc_br : pc_inc;
        end
`else
        pc_d = bus.flag ? pc_br : pc_inc;
`endif
      end
      2'b11: pc_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= 16'h0000;
      ir_q     <= 16'h0000;
      opcode_q <= 4'h0;
      rd_q     <= 4'h0;
      ra_q     <= 4'h0;
      rb_q     <= 4'h0;
      imm_q    <= 8'h00;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      imm_q    <= imm_d;
    end
  end

`ifdef RETURN_STACK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) stk_q[i] <= 16'h0000;
      sp_q  <= 2'd0;
      cnt_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.stack_err = err_q;
`else
  assign bus.stack_err = 1'b0;
`endif

  assign bus.imem_addr = pc_q;
  assign bus.opcode    = opcode_q;
  assign bus.rD_sel    = rd_q;
  assign bus.rA_sel    = ra_q;
  assign bus.rB_sel    = rb_q;
  assign bus.imm       = imm_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the PC/IR/decode path plus
// hand sequences for asynchronous reset and (when RETURN_STACK_EN) the return stack.
module tb_fetch_unit;
  logic clock;
  logic reset;
  int   n_chk;
  int   n_err;

  fetch_unit_if bus ();

  fetch_unit u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iw;
    logic        de;
    logic [1:0]  op;
    logic        fl;
    logic [15:0] data;
    logic [15:0] e_pc;
    logic [15:0] e_fld;  // {opcode, rD, rA, rB}; imm is its low byte
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_fields(input string name, input logic [15:0] exp);
    chk({name, ".fields"}, {bus.opcode, bus.rD_sel, bus.rA_sel, bus.rB_sel}, exp);
    chk({name, ".imm"}, {8'h00, bus.imm}, {8'h00, exp[7:0]});
  endtask

  task automatic cycle(input logic iw, input logic de, input logic [1:0] op,
                       input logic fl, input logic [15:0] data);
    @(negedge clock);
    bus.inst_wr    = iw;
    bus.decoder_en = de;
    bus.pc_op      = op;
    bus.flag       = fl;
    bus.imem_data  = data;
    @(posedge clock);
    #1;
  endtask

  // Load an instruction word into IR and then onto the field outputs, PC held.
  task automatic load_decode(input logic [15:0] word);
    cycle(1'b1, 1'b0, 2'b00, 1'b0, word);
    cycle(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    bus.inst_wr = 1'b0; bus.decoder_en = 1'b0; bus.pc_op = 2'b00; bus.flag = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.inst_wr = 1'b0; bus.decoder_en = 1'b0; bus.pc_op = 2'b00;
    bus.flag = 1'b0; bus.imem_data = 16'h0000;

    //           iw    de    op     fl    data      e_pc      e_fld
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 16'h0040, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0040};
    vecs[2]  = '{1'b0, 1'b0, 2'b10, 1'b1, 16'h0000, 16'h0040, 16'h0040};
    vecs[3]  = '{1'b1, 1'b1, 2'b00, 1'b0, 16'h00F0, 16'h0040, 16'h0040};
    vecs[4]  = '{1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0040, 16'h00F0};
    vecs[5]  = '{1'b0, 1'b0, 2'b10, 1'b1, 16'h0000, 16'h0030, 16'h00F0};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 16'h0010, 16'h0030, 16'h00F0};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0030, 16'h0010};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 1'b1, 16'h0000, 16'h0040, 16'h0010};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 1'b0, 16'h00F0, 16'h0040, 16'h0010};
    vecs[10] = '{1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0040, 16'h00F0};
    vecs[11] = '{1'b0, 1'b0, 2'b10, 1'b0, 16'h0000, 16'h0041, 16'h00F0};
    vecs[12] = '{1'b0, 1'b0, 2'b11, 1'b1, 16'h0000, 16'h0000, 16'h00F0};
    vecs[13] = '{1'b0, 1'b0, 2'b01, 1'b0, 16'h0000, 16'h0001, 16'h00F0};
    vecs[14] = '{1'b0, 1'b0, 2'b00, 1'b1, 16'h0000, 16'h0001, 16'h00F0};
    vecs[15] = '{1'b1, 1'b0, 2'b11, 1'b0, 16'h0010, 16'h0000, 16'h00F0};
    vecs[16] = '{1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0010};
    vecs[17] = '{1'b0, 1'b0, 2'b10, 1'b1, 16'h0000, 16'h0010, 16'h0010};
    vecs[18] = '{1'b1, 1'b0, 2'b01, 1'b0, 16'hA5C3, 16'h0011, 16'h0010};
    vecs[19] = '{1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'h0011, 16'hA5C3};
    vecs[20] = '{1'b0, 1'b0, 2'b10, 1'b1, 16'h0000, 16'hFFD4, 16'hA5C3};
    vecs[21] = '{1'b1, 1'b0, 2'b00, 1'b0, 16'h002B, 16'hFFD4, 16'hA5C3};
    vecs[22] = '{1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 16'hFFD4, 16'h002B};
    vecs[23] = '{1'b0, 1'b0, 2'b10, 1'b1, 16'h0000, 16'hFFFF, 16'h002B};
    vecs[24] = '{1'b0, 1'b0, 2'b01, 1'b0, 16'h0000, 16'h0000, 16'h002B};

    // Reset state, observed before any clock edge.
    #3;
    chk("reset.pc", bus.imem_addr, 16'h0000);
    chk_fields("reset", 16'h0000);
    chk("reset.stack_err", {15'd0, bus.stack_err}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      cycle(vecs[i].iw, vecs[i].de, vecs[i].op, vecs[i].fl, vecs[i].data);
      chk($sformatf("vec%0d.pc", i), bus.imem_addr, vecs[i].e_pc);
      chk_fields($sformatf("vec%0d", i), vecs[i].e_fld);
      chk($sformatf("vec%0d.stack_err", i), {15'd0, bus.stack_err}, 16'h0000);
    end

    // Reach PC=0123, then assert reset mid-cycle with work pending.
    cycle(1'b1, 1'b0, 2'b11, 1'b0, 16'h007F);
    cycle(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 2'b10, 1'b1, 16'h0000);
    cycle(1'b0, 1'b0, 2'b10, 1'b1, 16'h0000);
    load_decode(16'h0025);
    cycle(1'b0, 1'b0, 2'b10, 1'b1, 16'h0000);
    chk("pre_reset.pc", bus.imem_addr, 16'h0123);
    @(negedge clock);
    bus.inst_wr = 1'b1; bus.decoder_en = 1'b1; bus.pc_op = 2'b01; bus.imem_data = 16'hFFFF;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset.pc", bus.imem_addr, 16'h0000);
    chk("async_reset.opcode", {12'd0, bus.opcode}, 16'h0000);
    chk("async_reset.stack_err", {15'd0, bus.stack_err}, 16'h0000);
    @(posedge clock);
    #1;
    chk("held_reset.pc", bus.imem_addr, 16'h0000);
    chk_fields("held_reset", 16'h0000);
    cycle(1'b0, 1'b0, 2'b01, 1'b0, 16'h0000);
    chk("reset_release.pc_not_early", bus.imem_addr, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("reset_release.first_edge", bus.imem_addr, 16'h0001);
    chk_fields("reset_release", 16'h0000);

`ifdef RETURN_STACK_EN
    cycle(1'b1, 1'b0, 2'b11, 1'b0, 16'h0020);
    cycle(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 2'b10, 1'b1, 16'h0000);
    chk("stk.setup_pc", bus.imem_addr, 16'h0020);
    load_decode(16'hD010);
    cycle(1'b0, 1'b0, 2'b10, 1'b0, 16'h0000);
    chk("stk.call_pc", bus.imem_addr, 16'h0030);
    chk("stk.call_err", {15'd0, bus.stack_err}, 16'h0000);
    load_decode(16'hE000);
    cycle(1'b0, 1'b0, 2'b10, 1'b0, 16'h0000);
    chk("stk.ret_pc", bus.imem_addr, 16'h0021);
    load_decode(16'hD010);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 2'b10, 1'b1, 16'h0000);
    chk("stk.four_calls_pc", bus.imem_addr, 16'h0061);
    chk("stk.four_calls_err", {15'd0, bus.stack_err}, 16'h0000);
    cycle(1'b0, 1'b0, 2'b10, 1'b0, 16'h0000);
    chk("stk.fifth_call_pc", bus.imem_addr, 16'h0071);
    chk("stk.overflow_err", {15'd0, bus.stack_err}, 16'h0001);
    load_decode(16'hE000);
    cycle(1'b0, 1'b0, 2'b10, 1'b0, 16'h0000);
    chk("stk.ret_after_wrap_pc", bus.imem_addr, 16'h0062);
    pulse_reset();
    chk("stk.err_cleared", {15'd0, bus.stack_err}, 16'h0000);

    load_decode(16'h0050);
    cycle(1'b0, 1'b0, 2'b10, 1'b1, 16'h0000);
    chk("stk.empty_setup_pc", bus.imem_addr, 16'h0050);
    load_decode(16'hE000);
    cycle(1'b0, 1'b0, 2'b10, 1'b1, 16'h0000);
    chk("stk.underflow_pc", bus.imem_addr, 16'h0051);
    chk("stk.underflow_err", {15'd0, bus.stack_err}, 16'h0001);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 2'b01, 1'b0, 16'h0000);
    chk("stk.err_sticky_pc", bus.imem_addr, 16'h0054);
    chk("stk.err_sticky", {15'd0, bus.stack_err}, 16'h0001);
    pulse_reset();
    chk("stk.err_reset", {15'd0, bus.stack_err}, 16'h0000);
`else
    load_decode(16'hD010);
    cycle(1'b0, 1'b0, 2'b10, 1'b0, 16'h0000);
    chk("nostk.d_flag0_pc", bus.imem_addr, 16'h0002);
    cycle(1'b0, 1'b0, 2'b10, 1'b1, 16'h0000);
    chk("nostk.d_flag1_pc", bus.imem_addr, 16'h0012);
    load_decode(16'hE000);
    cycle(1'b0, 1'b0, 2'b10, 1'b0, 16'h0000);
    chk("nostk.e_flag0_pc", bus.imem_addr, 16'h0013);
    chk("nostk.stack_err", {15'd0, bus.stack_err}, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: inst_wr  input  1  capture imem_data into instruction register (IR).
REQ-004 SHALL have port: decoder_en  input  1  latch decoded IR fields onto field outputs.
REQ-005 SHALL have port: pc_op  input  2  PC operation: 00 hold, 01 increment, 10 branch, 11 clear.
REQ-006 SHALL have port: flag  input  1  branch condition from the datapath.
REQ-007 SHALL have port: imem_data  input  16  instruction word at imem_addr.
REQ-008 SHALL have port: imem_addr  output  16  current PC value.
REQ-009 SHALL have port: opcode  output  4  IR[15:12], latched.
REQ-010 SHALL have port: rD_sel, rA_sel, rB_sel  output  4 each  IR[11:8], IR[7:4], IR[3:0], latched.
REQ-011 SHALL have port: imm  output  8  IR[7:0], latched.
REQ-012 SHALL have port: stack_err  output  1  sticky return-stack overflow/underflow (0 when stack compiled out).

Function
REQ-013 PC SHALL update only on a rising clock edge, from its pre-edge value.
REQ-014 pc_op 00: PC unchanged.
REQ-015 pc_op 01: PC <= PC + 1, modulo 2^16 (FFFF wraps to 0000).
REQ-016 pc_op 10 with flag=1: PC <= PC + sign-extended imm (latched value), modulo 2^16.
REQ-017 pc_op 10 with flag=0: PC <= PC + 1.
REQ-018 pc_op 11: PC <= 0000, synchronously.
REQ-019 imem_addr SHALL equal PC combinationally (no extra latency).
REQ-020 inst_wr=1: IR <= imem_data at the edge; IR holds otherwise.
REQ-021 decoder_en=1: field outputs <= slices of IR (pre-edge IR) at the edge; hold otherwise.
REQ-022 inst_wr and pc_op active in the same cycle: IR SHALL capture the word at the pre-edge PC; PC updates normally.
REQ-023 inst_wr and decoder_en in the same cycle: field outputs SHALL take the old IR (one-cycle pipeline).
REQ-024 Fetch-to-field latency SHALL be exactly 2 edges (inst_wr edge, then decoder_en edge).

Reset
REQ-025 reset low SHALL immediately force PC=0000, IR=0000, all field outputs 0, stack pointer 0, stack_err 0, stack entries 0.
REQ-026 Reset assertion mid-operation SHALL override every pending pc_op, inst_wr, decoder_en.
REQ-027 First state change after reset release SHALL occur on the first rising edge with reset high.

Configuration
REQ-028 Macro RETURN_STACK_EN SHALL compile in a 4-entry, 16-bit return-address stack.
REQ-029 With macro, pc_op 10 and latched opcode 4'hD (CALL): push PC+1, then PC <= PC + sext(imm), regardless of flag.
REQ-030 With macro, pc_op 10 and latched opcode 4'hE (RET): pop, PC <= popped entry, regardless of flag.
REQ-031 Push when 4 entries held: overwrite oldest (pointer wraps), set stack_err; branch still taken.
REQ-032 Pop when empty: PC <= PC + 1, set stack_err; stack_err clears only on reset.
REQ-033 Without macro, opcodes D and E SHALL follow REQ-016/017, no stack storage, stack_err tied 0.

Verification
REQ-034 Reset low mid-run with PC=0123 -> PC=0000, opcode=0, stack_err=0 before next edge.
REQ-035 PC=FFFF, pc_op=01 -> PC=0000 next edge.
REQ-036 IR fields imm=F0, PC=0040, pc_op=10, flag=1 -> PC=0030; same with flag=0 -> PC=0041.
REQ-037 imem_data=A5C3 at PC=0010, inst_wr then decoder_en -> opcode=A, rD_sel=5, rA_sel=C, rB_sel=3, imm=C3 after 2nd edge.
REQ-038 RETURN_STACK_EN: CALL at PC=0020 imm=10 -> PC=0030; RET -> PC=0021; 5 nested CALLs -> stack_err=1.
REQ-039 RETURN_STACK_EN: RET on empty stack at PC=0050 -> PC=0051, stack_err=1 held until reset.
